// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, halt on out-of-range PC.
// Optional macro FETCH_ALIGN_CHECK_EN enables word-aligning redirects with a sticky align_err flag.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_addr,
  input  logic [31:0] instr_in,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halted,
  output logic [15:0] fetch_count,
  output logic        align_err
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        in_range;
  logic [31:0] target;

  assign pc_addr  = pc;
  assign pc_plus4 = pc + 32'd4;
  // 33-bit compare so a PC near 2^32 cannot wrap into the valid window
  assign in_range = ({1'b0, pc} + 33'd4) <= 33'(MEM_BYTES);

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = |redirect_pc[1:0];
  assign target     = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      align_err <= 1'b0;
    end else if (redirect && misaligned) begin
      align_err <= 1'b1;
    end
  end
`else
  assign target    = redirect_pc;
  assign align_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      ifid_instr  <= '0;
      ifid_pc4    <= '0;
      ifid_valid  <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else if (redirect) begin
      pc         <= target;
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
      halted     <= 1'b0;
    end else if (stall) begin
      // hold everything
    end else if (halted) begin
      ifid_valid <= 1'b0;
    end else if (in_range) begin
      pc         <= pc_plus4;
      ifid_instr <= instr_in;
      ifid_pc4   <= pc_plus4;
      ifid_valid <= 1'b1;
      if (fetch_count != '1) begin
        fetch_count <= fetch_count + 16'd1;
      end
    end else begin
      halted     <= 1'b1;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
    end
  end

endmodule
